// File: rtl/pwr_domain_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pwr_domain_ctrl_pkg
//   Shared types and constants for the multi-domain power-gating controller.
//   - pwr_state_t : per-domain power sequencing state
//   - NOP_OP      : opcode that counts as an idle instruction slot
// ---------------------------------------------------------------------------
package pwr_domain_ctrl_pkg;

   typedef enum logic [2:0] {
      ON     = 3'd0,
      ISO    = 3'd1,
      OFF    = 3'd2,
      PWRUP  = 3'd3,
      RSTREL = 3'd4,
      ISOREL = 3'd5
   } pwr_state_t;

   localparam logic [5:0] NOP_OP = 6'b001000;

endpackage

// File: rtl/pwr_domain_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwr_domain_ctrl_if
//   Bundle between the power controller and its environment (core + header
//   switches).
//   opcode    : instr[31:26] of the current instruction
//   dom_busy  : per-domain pending work
//   sw_ack    : per-domain power-good from header switch
//   sw_en     : per-domain switch closed
//   iso_en    : per-domain output clamp
//   dom_rst   : per-domain reset
//   dom_ready : per-domain ON indication
//   pwr_err   : per-domain sticky sw_ack timeout flag
//   stall     : core stall request
//   master = controller side, slave = environment side.
// ---------------------------------------------------------------------------
interface pwr_domain_ctrl_if #(
   parameter int unsigned N_DOM = 2
);
   logic [5:0]       opcode;
   logic [N_DOM-1:0] dom_busy;
   logic [N_DOM-1:0] sw_ack;
   logic [N_DOM-1:0] sw_en;
   logic [N_DOM-1:0] iso_en;
   logic [N_DOM-1:0] dom_rst;
   logic [N_DOM-1:0] dom_ready;
   logic [N_DOM-1:0] pwr_err;
   logic             stall;

   modport master (
      input  opcode, dom_busy, sw_ack,
      output sw_en, iso_en, dom_rst, dom_ready, pwr_err, stall
   );

   modport slave (
      output opcode, dom_busy, sw_ack,
      input  sw_en, iso_en, dom_rst, dom_ready, pwr_err, stall
   );
endinterface

// File: rtl/pwr_domain_ctrl_dom_fsm.sv
// ---------------------------------------------------------------------------
// pwr_dom_fsm
//   One power domain: idle counter, sequencing timer and power FSM.
//   Power-down: ON -> ISO (clamp) -> OFF (switch open).
//   Wake:       OFF -> PWRUP -> RSTREL -> ISOREL -> ON.
//   Ports:
//     clk, reset  : clock, synchronous active-low reset
//     i_idle      : domain idle this cycle
//     i_sw_ack    : power-good from the header switch
//     o_sw_en     : switch closed
//     o_iso_en    : outputs clamped
//     o_dom_rst   : domain held in reset
//     o_dom_ready : domain in ON
//     o_pwr_err   : sticky sw_ack timeout
//   All outputs are registered, decoded from the next state.
// ---------------------------------------------------------------------------
module pwr_dom_fsm
   import pwr_domain_ctrl_pkg::*;
#(
   parameter int unsigned IDLE_THRESH = 10,
   parameter int unsigned ISO_CYC     = 2,
   parameter int unsigned RST_CYC     = 2,
   parameter int unsigned PWR_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic i_idle,
   input  logic i_sw_ack,
   output logic o_sw_en,
   output logic o_iso_en,
   output logic o_dom_rst,
   output logic o_dom_ready,
   output logic o_pwr_err
);

   localparam int unsigned CNT_W   = $clog2(IDLE_THRESH + 1);
   localparam int unsigned TMR_MX1 = (ISO_CYC > RST_CYC) ? ISO_CYC : RST_CYC;
   localparam int unsigned TMR_MAX = (TMR_MX1 > PWR_TIMEOUT) ? TMR_MX1 : PWR_TIMEOUT;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_THRESH);
   localparam logic [TMR_W-1:0] ISO_LAST = TMR_W'(ISO_CYC - 1);
   localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYC - 1);
   localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(PWR_TIMEOUT - 1);

   pwr_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
   logic             r_err, w_err_set;
   logic             r_sw_en, r_iso_en, r_dom_rst, r_dom_ready;

   // Timer defaults to zero so every state change starts it fresh; timed
   // states increment it explicitly while they stay put.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_tmr_nxt   = '0;
      w_err_set   = 1'b0;
      case (r_state)
         ON: begin
            if (i_idle) begin
               if (r_cnt == CNT_MAX) begin
                  w_state_nxt = ISO;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         ISO: begin
            if (!i_idle) begin
               w_state_nxt = ON;
            end else if (r_tmr == ISO_LAST) begin
               w_state_nxt = OFF;
            end else begin
               w_tmr_nxt = r_tmr + 1'b1;
            end
         end
         OFF: begin
            if (!i_idle) begin
               w_state_nxt = PWRUP;
            end
         end
         PWRUP: begin
            if (i_sw_ack) begin
               w_state_nxt = RSTREL;
            end else if (r_tmr == TO_LAST) begin
               // Switch never reported power-good: proceed anyway and flag it.
               w_state_nxt = RSTREL;
               w_err_set   = 1'b1;
            end else begin
               w_tmr_nxt = r_tmr + 1'b1;
            end
         end
         RSTREL: begin
            if (r_tmr == RST_LAST) begin
               w_state_nxt = ISOREL;
            end else begin
               w_tmr_nxt = r_tmr + 1'b1;
            end
         end
         ISOREL: begin
            w_state_nxt = ON;
         end
         default: begin
            w_state_nxt = ON;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ON;
         r_cnt       <= '0;
         r_tmr       <= '0;
         r_err       <= 1'b0;
         r_sw_en     <= 1'b1;
         r_iso_en    <= 1'b0;
         r_dom_rst   <= 1'b0;
         r_dom_ready <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_tmr       <= w_tmr_nxt;
         r_err       <= r_err | w_err_set;
         r_sw_en     <= (w_state_nxt != OFF);
         r_iso_en    <= (w_state_nxt == ISO) || (w_state_nxt == OFF) ||
                        (w_state_nxt == PWRUP) || (w_state_nxt == RSTREL);
         r_dom_rst   <= (w_state_nxt == RSTREL);
         r_dom_ready <= (w_state_nxt == ON);
      end
   end

   assign o_sw_en     = r_sw_en;
   assign o_iso_en    = r_iso_en;
   assign o_dom_rst   = r_dom_rst;
   assign o_dom_ready = r_dom_ready;
   assign o_pwr_err   = r_err;

endmodule

// File: rtl/pwr_domain_ctrl.sv
// ---------------------------------------------------------------------------
// pwr_domain_ctrl
//   Multi-domain power-gating controller. Watches the core opcode and
//   per-domain busy flags, and sequences each domain's header switch,
//   isolation clamp and reset independently.
//   Ports:
//     clk    : system clock
//     reset  : synchronous active-low reset
//     io_pwr : controller side of pwr_domain_ctrl_if (opcode, dom_busy,
//              sw_ack in; sw_en, iso_en, dom_rst, dom_ready, pwr_err,
//              stall out)
// ---------------------------------------------------------------------------
module pwr_domain_ctrl
   import pwr_domain_ctrl_pkg::*;
#(
   parameter int unsigned N_DOM       = 2,
   parameter int unsigned IDLE_THRESH = 10,
   parameter int unsigned ISO_CYC     = 2,
   parameter int unsigned RST_CYC     = 2,
   parameter int unsigned PWR_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   pwr_domain_ctrl_if.master  io_pwr
);

   logic             w_nop;
   logic [N_DOM-1:0] w_idle;
   logic [N_DOM-1:0] w_sw_en;
   logic [N_DOM-1:0] w_iso_en;
   logic [N_DOM-1:0] w_dom_rst;
   logic [N_DOM-1:0] w_dom_ready;
   logic [N_DOM-1:0] w_pwr_err;

   assign w_nop  = (io_pwr.opcode == NOP_OP);
   assign w_idle = {N_DOM{w_nop}} & ~io_pwr.dom_busy;

   for (genvar g = 0; g < N_DOM; g++) begin : g_dom
      pwr_dom_fsm #(
         .IDLE_THRESH (IDLE_THRESH),
         .ISO_CYC     (ISO_CYC),
         .RST_CYC     (RST_CYC),
         .PWR_TIMEOUT (PWR_TIMEOUT)
      ) u_dom (
         .clk         (clk),
         .reset       (reset),
         .i_idle      (w_idle[g]),
         .i_sw_ack    (io_pwr.sw_ack[g]),
         .o_sw_en     (w_sw_en[g]),
         .o_iso_en    (w_iso_en[g]),
         .o_dom_rst   (w_dom_rst[g]),
         .o_dom_ready (w_dom_ready[g]),
         .o_pwr_err   (w_pwr_err[g])
      );
   end

   assign io_pwr.sw_en     = w_sw_en;
   assign io_pwr.iso_en    = w_iso_en;
   assign io_pwr.dom_rst   = w_dom_rst;
   assign io_pwr.dom_ready = w_dom_ready;
   assign io_pwr.pwr_err   = w_pwr_err;
   // Stall only while a domain with pending work is not yet usable.
   assign io_pwr.stall     = |(io_pwr.dom_busy & ~w_dom_ready);

endmodule

// File: tb/tb_pwr_domain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwr_domain_ctrl
//   Directed scoreboard bench for pwr_domain_ctrl (N_DOM=2, defaults).
//   Stimulus pushes expected per-domain states with a target cycle; the
//   monitor compares all outputs when that cycle is reached.
// ---------------------------------------------------------------------------
module tb_pwr_domain_ctrl;

   localparam int S_ON = 0, S_ISO = 1, S_OFF = 2, S_PWRUP = 3, S_RSTREL = 4, S_ISOREL = 5;
   localparam logic [5:0] OP_NOP = 6'b001000;
   localparam logic [5:0] OP_LW  = 6'b100011;

   typedef struct {
      int unsigned at;
      string       name;
      logic [10:0] exp;
   } chk_t;

   logic clk;
   logic reset;
   int unsigned cyc;
   int unsigned checks;
   int unsigned errors;
   chk_t q[$];

   pwr_domain_ctrl_if #(.N_DOM(2)) u_if ();

   pwr_domain_ctrl #(
      .N_DOM       (2),
      .IDLE_THRESH (10),
      .ISO_CYC     (2),
      .RST_CYC     (2),
      .PWR_TIMEOUT (15)
   ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .io_pwr (u_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {sw_en, iso_en, dom_rst, dom_ready} expected for one domain in state s
   function automatic logic [3:0] out4(input int s);
      case (s)
         S_ON:     return 4'b1001;
         S_ISO:    return 4'b1100;
         S_OFF:    return 4'b0100;
         S_PWRUP:  return 4'b1100;
         S_RSTREL: return 4'b1110;
         default:  return 4'b1000; // S_ISOREL
      endcase
   endfunction

   function automatic logic [10:0] mk(input int s1, input int s0,
                                      input logic [1:0] err, input logic st);
      logic [3:0] a, b;
      a = out4(s1);
      b = out4(s0);
      return {a[3], b[3], a[2], b[2], a[1], b[1], a[0], b[0], err, st};
   endfunction

   task automatic push(input int unsigned k, input string name, input int s1,
                       input int s0, input logic [1:0] err, input logic st);
      chk_t c;
      c.at   = cyc + k;
      c.name = name;
      c.exp  = mk(s1, s0, err, st);
      q.push_back(c);
   endtask

   // Monitor: samples 2ns after each rising edge.
   initial begin
      chk_t c;
      logic [10:0] act;
      cyc = 0;
      checks = 0;
      errors = 0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         while (q.size() > 0 && q[0].at <= cyc) begin
            c = q.pop_front();
            act = {u_if.sw_en, u_if.iso_en, u_if.dom_rst, u_if.dom_ready,
                   u_if.pwr_err, u_if.stall};
            checks++;
            if (c.at != cyc || act !== c.exp) begin
               errors++;
               $display("FAIL %s cyc=%0d (due %0d) sw/iso/rst/rdy/err/stall got=%b exp=%b",
                        c.name, cyc, c.at, act, c.exp);
            end
         end
      end
   end

   initial begin
      reset         = 1'b0;
      u_if.opcode   = 6'd0;
      u_if.dom_busy = 2'b00;
      u_if.sw_ack   = 2'b00;

      @(negedge clk);
      push(1, "por", S_ON, S_ON, 2'b00, 1'b0);
      @(negedge clk);

      // Both domains idle: power down, then wake into PWRUP and reset there.
      reset = 1'b1;
      u_if.opcode = OP_NOP;
      push(10, "a_cnt10", S_ON,  S_ON,  2'b00, 1'b0);
      push(11, "a_iso1",  S_ISO, S_ISO, 2'b00, 1'b0);
      push(12, "a_iso2",  S_ISO, S_ISO, 2'b00, 1'b0);
      push(13, "a_off",   S_OFF, S_OFF, 2'b00, 1'b0);
      repeat (13) @(negedge clk);
      u_if.dom_busy = 2'b11;
      push(1, "a_pwrup", S_PWRUP, S_PWRUP, 2'b00, 1'b1);
      push(3, "a_pwrup3", S_PWRUP, S_PWRUP, 2'b00, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      push(1, "rst_mid1", S_ON, S_ON, 2'b00, 1'b0);
      push(2, "rst_mid2", S_ON, S_ON, 2'b00, 1'b0);
      push(3, "rst_mid3", S_ON, S_ON, 2'b00, 1'b0);
      repeat (3) @(negedge clk);

      // Power both down again, then wake domain 0 only with immediate ack.
      reset = 1'b1;
      u_if.dom_busy = 2'b00;
      push(11, "b_iso", S_ISO, S_ISO, 2'b00, 1'b0);
      push(13, "b_off", S_OFF, S_OFF, 2'b00, 1'b0);
      repeat (13) @(negedge clk);
      u_if.dom_busy = 2'b01;
      u_if.sw_ack   = 2'b01;
      push(1, "w_pwrup",  S_OFF, S_PWRUP,  2'b00, 1'b1);
      push(2, "w_rstrel1", S_OFF, S_RSTREL, 2'b00, 1'b1);
      push(3, "w_rstrel2", S_OFF, S_RSTREL, 2'b00, 1'b1);
      push(4, "w_isorel", S_OFF, S_ISOREL, 2'b00, 1'b1);
      push(5, "w_ready",  S_OFF, S_ON,     2'b00, 1'b0);
      repeat (5) @(negedge clk);

      // Domain 0 reaches ISO and aborts; the same activity wakes domain 1,
      // whose switch never acknowledges.
      u_if.dom_busy = 2'b00;
      u_if.sw_ack   = 2'b00;
      push(10, "c_cnt10", S_OFF, S_ON,  2'b00, 1'b0);
      push(11, "c_iso",   S_OFF, S_ISO, 2'b00, 1'b0);
      repeat (11) @(negedge clk);
      u_if.opcode = OP_LW;
      push(1,  "c_abort",   S_PWRUP,  S_ON, 2'b00, 1'b0);
      push(15, "c_pwrup15", S_PWRUP,  S_ON, 2'b00, 1'b0);
      push(16, "c_timeout", S_RSTREL, S_ON, 2'b10, 1'b0);
      push(17, "c_rstrel2", S_RSTREL, S_ON, 2'b10, 1'b0);
      push(18, "c_isorel",  S_ISOREL, S_ON, 2'b10, 1'b0);
      push(19, "c_on",      S_ON,     S_ON, 2'b10, 1'b0);
      repeat (19) @(negedge clk);

      // 9 idle, 1 busy on domain 0, then idle: domain 0 restarts its count.
      u_if.opcode = OP_NOP;
      push(9,  "d_9idle",  S_ON,  S_ON,  2'b10, 1'b0);
      push(10, "d_busy",   S_ON,  S_ON,  2'b10, 1'b0);
      push(11, "d_iso1",   S_ISO, S_ON,  2'b10, 1'b0);
      push(13, "d_off1",   S_OFF, S_ON,  2'b10, 1'b0);
      push(20, "d_cnt10",  S_OFF, S_ON,  2'b10, 1'b0);
      push(21, "d_iso0",   S_OFF, S_ISO, 2'b10, 1'b0);
      push(23, "d_off0",   S_OFF, S_OFF, 2'b10, 1'b0);
      repeat (9) @(negedge clk);
      u_if.dom_busy = 2'b01;
      @(negedge clk);
      u_if.dom_busy = 2'b00;
      repeat (13) @(negedge clk);

      // Only reset clears the error flag.
      reset = 1'b0;
      push(1, "e_rst", S_ON, S_ON, 2'b00, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
